// File: rtl/pipe_ctrl_gen_pkg.sv
// Shared encodings for the pipeline stall/flush controller: exception codes,
// FSM states and stall polarity.
package pipe_ctrl_gen_pkg;

    localparam int EXC_TYPE_NULL    = 0;
    localparam int EXC_TYPE_INT     = 1;
    localparam int EXC_TYPE_ADEL    = 2;
    localparam int EXC_TYPE_ADES    = 3;
    localparam int EXC_TYPE_SYSCALL = 4;
    localparam int EXC_TYPE_BREAK   = 5;
    localparam int EXC_TYPE_RI      = 6;
    localparam int EXC_TYPE_OV      = 7;
    localparam int EXC_TYPE_TRAP    = 8;
    localparam int EXC_TYPE_ERET    = 9;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_gen_stall_mask.sv
// Thermometer stall mask: a stall request at stage i also holds every
// younger stage below it; a global bus wait holds everything.
module stall_mask_gen #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] stall_req,
    input  logic              global_stall_req,
    output logic [STAGES-1:0] stall
);
    import pipe_ctrl_gen_pkg::*;

    always_comb begin
        logic acc;
        acc   = global_stall_req;
        stall = {STAGES{NO_STOP}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc      = acc | stall_req[k];
            stall[k] = acc;
        end
    end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush controller with pending-exception capture during
// global stalls, a multi-cycle flush window and a saturating stall counter.
module pipe_ctrl_gen
    import pipe_ctrl_gen_pkg::*;
#(
    parameter int          STAGES       = 6,
    parameter int          ADDR_W       = 32,
    parameter int          EXC_W        = 5,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int          CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] stall_req,
    input  logic              global_stall_req,
    input  logic [EXC_W-1:0]  exc_type,
    input  logic [ADDR_W-1:0] cp0_epc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [ADDR_W-1:0] exc_pc,
    output logic              exc_pending,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int               FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]  FC_INIT = FC_W'(FLUSH_CYCLES - 1);
    localparam bit               MULTI   = (FLUSH_CYCLES > 1);
    localparam logic [ADDR_W-1:0] VEC    = ADDR_W'(EXC_VECTOR);

    state_t            state, state_nxt;
    logic [FC_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0] tgt, tgt_nxt;
    logic [ADDR_W-1:0] tgt_now;
    logic [STAGES-1:0] mask;
    logic [CNT_W-1:0]  stall_cnt;
    logic              exc_valid;
    logic              is_eret;

    stall_mask_gen #(.STAGES(STAGES)) u_mask (
        .stall_req        (stall_req),
        .global_stall_req (global_stall_req),
        .stall            (mask)
    );

    assign exc_valid = (exc_type != EXC_W'(EXC_TYPE_NULL));
    assign is_eret   = (exc_type == EXC_W'(EXC_TYPE_ERET));
    assign tgt_now   = is_eret ? cp0_epc : VEC;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tgt   <= tgt_nxt;
        end
    end

    // The redirect target is captured when the exception is first seen, so a
    // later EPC change while waiting out a bus stall does not move it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tgt_nxt   = tgt;
        unique case (state)
            IDLE: begin
                if (exc_valid) begin
                    tgt_nxt = tgt_now;
                    if (global_stall_req) begin
                        state_nxt = PEND;
                    end else if (MULTI) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FC_INIT;
                    end
                end
            end
            PEND: begin
                if (!global_stall_req) begin
                    if (MULTI) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = FC_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (cnt <= FC_W'(1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - FC_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall       = mask;
        flush       = 1'b0;
        exc_pc      = '0;
        exc_pending = 1'b0;
        if (!reset) begin
            stall = {STAGES{NO_STOP}};
        end else begin
            unique case (state)
                IDLE: begin
                    if (exc_valid && !global_stall_req) begin
                        flush  = 1'b1;
                        stall  = {STAGES{NO_STOP}};
                        exc_pc = tgt_now;
                    end
                end
                PEND: begin
                    exc_pending = 1'b1;
                    if (!global_stall_req) begin
                        flush  = 1'b1;
                        stall  = {STAGES{NO_STOP}};
                        exc_pc = tgt;
                    end
                end
                FLUSH: begin
                    flush  = 1'b1;
                    stall  = {STAGES{NO_STOP}};
                    exc_pc = tgt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if ((|stall) && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Table-driven bench for pipe_ctrl_gen: a default instance and one with a
// 3-cycle flush window and a 4-bit stall counter share the stimulus.
module tb_pipe_ctrl_gen;
    import pipe_ctrl_gen_pkg::*;

    localparam logic [4:0]  N  = 5'd0;
    localparam logic [4:0]  ER = 5'(EXC_TYPE_ERET);
    localparam logic [4:0]  SY = 5'(EXC_TYPE_SYSCALL);
    localparam logic [31:0] EV = 32'hBFC0_0380;
    localparam logic [5:0]  AL = 6'h3F;

    typedef struct {
        bit          dut_b;
        logic        rst;
        logic [5:0]  sreq;
        logic        gs;
        logic [4:0]  et;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_pend;
        bit          chk_pend;
        int          cnt_mode;
        int          e_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  stall_req;
    logic        global_stall_req;
    logic [4:0]  exc_type;
    logic [31:0] cp0_epc;

    logic [5:0]  stall_a, stall_b;
    logic        flush_a, flush_b;
    logic [31:0] pc_a, pc_b;
    logic        pend_a, pend_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   miscompares = 0;
    int   exp_cnt_a = 0;

    pipe_ctrl_gen dut_a (
        .clk(clk), .reset(rst_n), .stall_req(stall_req),
        .global_stall_req(global_stall_req), .exc_type(exc_type),
        .cp0_epc(cp0_epc), .stall(stall_a), .flush(flush_a),
        .exc_pc(pc_a), .exc_pending(pend_a), .stall_cycles(cnt_a)
    );

    pipe_ctrl_gen #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .reset(rst_n), .stall_req(stall_req),
        .global_stall_req(global_stall_req), .exc_type(exc_type),
        .cp0_epc(cp0_epc), .stall(stall_b), .flush(flush_b),
        .exc_pc(pc_b), .exc_pending(pend_b), .stall_cycles(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit b, logic r, logic [5:0] sq, logic gs,
                                logic [4:0] et, logic [31:0] epc,
                                logic [5:0] es, logic ef, logic [31:0] ep,
                                logic pd, bit cp, int cm, int ec);
        vec_t v;
        v.dut_b = b;  v.rst = r;  v.sreq = sq;  v.gs = gs;  v.et = et;
        v.epc = epc;  v.e_stall = es;  v.e_flush = ef;  v.e_pc = ep;
        v.e_pend = pd;  v.chk_pend = cp;  v.cnt_mode = cm;  v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL vec %0d %s: got %h, want %h", n_vec, name, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst_n = v.rst;  stall_req = v.sreq;  global_stall_req = v.gs;
        exc_type = v.et;  cp0_epc = v.epc;
        sb.push_back(v);
        #4;
        e = sb.pop_front();
        n_vec++;
        if (e.dut_b) begin
            chk("stall_b", 32'(stall_b), 32'(e.e_stall));
            chk("flush_b", 32'(flush_b), 32'(e.e_flush));
            chk("exc_pc_b", pc_b, e.e_pc);
            if (e.chk_pend) chk("pending_b", 32'(pend_b), 32'(e.e_pend));
            if (e.cnt_mode == 2) chk("stall_cycles_b", 32'(cnt_b), 32'(e.e_cnt));
        end else begin
            chk("stall", 32'(stall_a), 32'(e.e_stall));
            chk("flush", 32'(flush_a), 32'(e.e_flush));
            chk("exc_pc", pc_a, e.e_pc);
            if (e.chk_pend) chk("pending", 32'(pend_a), 32'(e.e_pend));
            if (e.cnt_mode == 1) chk("stall_cycles", cnt_a, 32'(exp_cnt_a));
        end
        @(posedge clk);
        if (!e.dut_b) begin
            if (!e.rst) exp_cnt_a = 0;
            else if (e.e_stall != 6'd0) exp_cnt_a++;
        end
    endtask

    initial begin
        rst_n = 1'b0;  stall_req = '0;  global_stall_req = 1'b0;
        exc_type = N;  cp0_epc = '0;
        repeat (2) @(posedge clk);

        // reset forcing and thermometer mask
        tbl.push_back(mk(0, 0, AL,        1, SY, 32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'b000100, 0, N,  32'h0,        6'b000111, 0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'b001000, 0, N,  32'h0,        6'b001111, 0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'b100001, 0, N,  32'h0,        AL,        0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, N,  32'h0,        AL,        0, 32'h0,        0, 1, 1, 0));
        // immediate ERET and non-ERET flushes
        tbl.push_back(mk(0, 1, 6'b000010, 0, ER, 32'h80000100, 6'h00,     1, 32'h80000100, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'b000010, 0, N,  32'h80000100, 6'b000011, 0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, SY, 32'h00001234, 6'h00,     1, EV,           0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        // exception held across a global stall; second exception dropped
        tbl.push_back(mk(0, 1, 6'h00,     1, SY, 32'h11110000, AL,        0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, N,  32'h22220000, AL,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, ER, 32'h33330000, AL,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, N,  32'h0,        AL,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, ER, 32'h44440000, 6'h00,     1, EV,           0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        // pending ERET keeps the EPC seen at capture
        tbl.push_back(mk(0, 1, 6'h00,     1, ER, 32'h55550000, AL,        0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, N,  32'h66660000, AL,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h77770000, 6'h00,     1, 32'h55550000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        // reset while pending discards the exception
        tbl.push_back(mk(0, 1, 6'h00,     1, SY, 32'h0,        AL,        0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     1, N,  32'h0,        AL,        0, 32'h0,        1, 1, 1, 0));
        tbl.push_back(mk(0, 0, AL,        1, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 1, 0));

        // 3-cycle flush window on the second instance
        tbl.push_back(mk(1, 0, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 6'h00,     0, SY, 32'h0,        6'h00,     1, EV,           0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 6'b111000, 0, N,  32'h0,        6'h00,     1, EV,           0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 6'b000001, 1, ER, 32'h77770000, 6'h00,     1, EV,           0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 6'b000001, 0, N,  32'h0,        6'b000001, 0, 32'h0,        0, 1, 2, 0));
        tbl.push_back(mk(1, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 6'h00,     1, ER, 32'h12340000, AL,        0, 32'h0,        0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 6'h00,     1, N,  32'h0,        AL,        0, 32'h0,        1, 1, 2, 2));
        tbl.push_back(mk(1, 1, 6'h00,     0, N,  32'h0,        6'h00,     1, 32'h12340000, 0, 0, 2, 3));
        tbl.push_back(mk(1, 1, 6'b010000, 0, N,  32'h0,        6'h00,     1, 32'h12340000, 0, 1, 2, 3));
        tbl.push_back(mk(1, 1, 6'b010000, 0, N,  32'h0,        6'h00,     1, 32'h12340000, 0, 1, 2, 3));
        tbl.push_back(mk(1, 1, 6'b010000, 0, N,  32'h0,        6'b011111, 0, 32'h0,        0, 1, 2, 3));
        tbl.push_back(mk(1, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 4));

        // 4-bit stall counter saturation
        tbl.push_back(mk(1, 0, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 4));
        tbl.push_back(mk(1, 0, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(1, 1, 6'b000001, 0, N, 32'h0, 6'b000001, 0, 32'h0, 0, 1, 2,
                             (i < 15) ? i : 15));
        tbl.push_back(mk(1, 1, 6'h00,     0, N,  32'h0,        6'h00,     0, 32'h0,        0, 1, 2, 15));

        foreach (tbl[i]) apply(tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_gen.md
Name: pipe_ctrl_gen

Overview:
- Parametrised successor to the CPU's pipeline stall/flush controller; sits beside the datapath and drives per-stage stall and flush.
- Generalises the stage count and stall-request sources.
- Adds a pending-exception register so exceptions arriving during a global (IF/MEM bus) stall are held, not lost.
- Adds a multi-cycle flush window and a saturating stall-cycle performance counter.

Parameters:
STAGES, 6, number of pipeline stages; stall bit 0 = PC/IF, bit STAGES-1 = WB
ADDR_W, 32, PC/EPC width
EXC_W, 5, exception-type code width
FLUSH_CYCLES, 1, cycles flush stays asserted per accepted exception (>=1)
EXC_VECTOR, 32'hBFC00380, redirect PC for all non-ERET exceptions
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
stall_req  in  STAGES  stall_req[i]=1: stage i requests stall of stages 0..i
global_stall_req  in  1  IF/MEM bus wait; freezes all stages
exc_type  in  EXC_W  exception type from MEM/commit; EXC_TYPE_NULL = none
cp0_epc  in  ADDR_W  current CP0 EPC
stall  out  STAGES  per-stage stall, 1 = hold
flush  out  1  pipeline flush
exc_pc  out  ADDR_W  redirect target, valid while flush=1
exc_pending  out  1  exception captured and waiting for global stall to drop
stall_cycles  out  CNT_W  saturating count of cycles with any stall bit set

Behaviour:
- Reset (reset=0 at posedge):
  - FSM goes to IDLE; flush counter, pending registers and stall_cycles clear.
  - While reset=0, combinational outputs are forced: stall=0, flush=0, exc_pc=0, exc_pending=0.
- Stall mask (combinational, same cycle), when not flushing:
  - global_stall_req=1 -> stall = all ones.
  - Else stall[k] = OR of stall_req[j] for j>=k (thermometer from highest requesting stage down to 0).
  - Example, STAGES=6: stall_req=000100 -> stall=000111.
- FSM states: IDLE, PEND, FLUSH.
- IDLE:
  - exc_type!=NULL and global_stall_req=0:
    - flush=1 combinationally this cycle; stall=0.
    - exc_pc = cp0_epc if exc_type==EXC_TYPE_ERET, else EXC_VECTOR.
    - If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1 and exc_pc latched.
  - exc_type!=NULL and global_stall_req=1:
    - Latch type and target (EPC sampled now); go to PEND.
    - stall = all ones; flush=0.
- PEND:
  - exc_pending=1; incoming exc_type is ignored.
  - While global_stall_req=1: stall = all ones, flush=0.
  - First cycle global_stall_req=0: flush=1, exc_pc = latched target, stall=0.
  - Then go to FLUSH (if FLUSH_CYCLES>1) or IDLE.
- FLUSH:
  - flush=1, stall=0, exc_pc = latched target; counter decrements each cycle.
  - Go to IDLE when counter reaches 1.
  - exc_type and stall requests are ignored (pipeline is being cleared).
- Priority within a cycle:
  - reset > active flush > global stall > highest-index stall_req.
  - An exception with global_stall_req=1 never flushes in that cycle.
- exc_pc = 0 whenever flush=0.
- stall_cycles:
  - Increments at posedge when stall!=0 and reset=1.
  - Holds at all-ones (saturates, no wrap).
- No latches: every combinational output is assigned on all paths.

Decomposition:
- Shared package/defines: EXC_TYPE_NULL (0), EXC_TYPE_ERET, the other EXC_TYPE codes, EXC_VECTOR default, FSM state encoding (IDLE=0, PEND=1, FLUSH=2), Stop/NoStop constants.
- Sub-module stall_mask_gen (parameter STAGES): stall_req + global_stall_req -> thermometer stall vector.

Test Plan:
1. STAGES=6, stall_req=000100 then 001000 -> stall=000111, then 001111; flush=0; stall_cycles increments by 1 per cycle.
2. IDLE, exc_type=ERET, cp0_epc=0x8000_0100, global_stall_req=0 -> same-cycle flush=1, exc_pc=0x8000_0100, stall=0; next cycle flush=0 (FLUSH_CYCLES=1).
3. Non-ERET exception with global_stall_req=1 for 3 cycles, EPC changes after capture -> stall=111111 and exc_pending=1 for 3 cycles; 4th cycle flush=1, exc_pc=EXC_VECTOR; second exception during PEND is dropped.
4. FLUSH_CYCLES=3, exception accepted -> flush high exactly 3 consecutive cycles with exc_pc stable; stall_req asserted during the window gives stall=0.
5. reset=0 asserted while in PEND -> next cycle all outputs 0, stall_cycles=0; after release, no flush occurs.
6. CNT_W=4, stall held 20 cycles -> stall_cycles saturates at 15.
